seq_det_arbiter: RTL and testbench

- Shares one serial pattern detector (ports clk/rstn/in/out, 1-bit match output) between N_REQ requesters.
- Each requester hands over a BURST_W-bit burst. The block grants one requester at a time and clears the detector between bursts, so no match can straddle two owners.
- It shifts the burst into the detector LSB first, counts det_out pulses, and reports a per-burst hit count tagged with the requester id.
- Sits between the requester-side packet logic and the single sequencer_detector instance.

---
 rtl/seq_det_arb_pkg.sv | 25 ++
 rtl/seq_det_arbiter_rr.sv | 51 +++++
 rtl/seq_det_arbiter.sv | 152 +++++++++++++++
 tb/tb_seq_det_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_arb_pkg
// Purpose  : Shared FSM state type and width helper for seq_det_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int DEFAULT_N_REQ = 4;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin request picker searching upward from ptr with wrap.
//            SEQ_DET_ARB_FIXED_PRIO_EN selects lowest-index-wins instead.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import seq_det_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);

    int              w_sum;
    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        w_sum     = 0;
        w_idx     = '0;
        w_found   = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
            w_sum = i;
`else
            w_sum = int'(ptr) + i;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
`endif
            w_idx = ID_W'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found   = 1'b1;
                grant_idx = w_idx;
            end
        end
    end

    assign any_req = |req;
    assign grant   = any_req ? (N_REQ'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_arbiter
// Purpose  : Time-shares one serial pattern detector between N_REQ requesters,
//            clearing it between bursts and reporting per-burst hit counts.
//            Optional macro: SEQ_DET_ARB_FIXED_PRIO_EN (fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_arbiter
    import seq_det_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int BURST_W = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*BURST_W-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     det_rstn,
    output logic                     det_in,
    input  logic                     det_out,
    output logic                     done_valid,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [CNT_W-1:0]         done_hits,
    output logic                     busy
);

    localparam int c_id_w  = id_w(N_REQ);
    localparam int c_bit_w = id_w(BURST_W);
    localparam int c_lat_w = id_w(DET_LAT);

    state_t             r_state;
    logic [c_id_w-1:0]  r_rr_ptr;
    logic [c_id_w-1:0]  r_gnt_idx;
    logic [BURST_W-1:0] r_burst;
    logic [c_bit_w-1:0] r_bit_idx;
    logic [c_lat_w-1:0] r_drain_cnt;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   w_hit_next;
    logic [N_REQ-1:0]   w_gnt;
    logic [c_id_w-1:0]  w_gnt_idx;
    logic               w_any_req;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (c_id_w)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_gnt),
        .grant_idx (w_gnt_idx),
        .any_req   (w_any_req)
    );

    // Saturating increment on a detector match.
    always_comb begin
        w_hit_next = r_hit_cnt;
        if (det_out && (r_hit_cnt != {CNT_W{1'b1}})) begin
            w_hit_next = r_hit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_burst     <= '0;
            r_bit_idx   <= '0;
            r_drain_cnt <= '0;
            r_hit_cnt   <= '0;
            req_ready   <= '0;
            det_rstn    <= 1'b0;
            det_in      <= 1'b0;
            done_valid  <= 1'b0;
            done_id     <= '0;
            done_hits   <= '0;
            busy        <= 1'b0;
        end else begin
            req_ready  <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_hits  <= '0;
            case (r_state)
                IDLE: begin
                    det_in <= 1'b0;
                    if (w_any_req) begin
                        r_state   <= CLEAR;
                        r_gnt_idx <= w_gnt_idx;
                        r_burst   <= req_data[int'(w_gnt_idx)*BURST_W +: BURST_W];
                        req_ready <= w_gnt;
                        det_rstn  <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        det_rstn <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_state   <= SHIFT;
                    r_hit_cnt <= '0;
                    r_bit_idx <= '0;
                    det_rstn  <= 1'b1;
                    det_in    <= r_burst[0];
                    r_burst   <= r_burst >> 1;
`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
                    r_rr_ptr  <= '0;
`else
                    r_rr_ptr  <= (r_gnt_idx == c_id_w'(N_REQ - 1)) ? '0
                                                                   : r_gnt_idx + c_id_w'(1);
`endif
                end
                SHIFT: begin
                    r_hit_cnt <= w_hit_next;
                    if (r_bit_idx == c_bit_w'(BURST_W - 1)) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                        det_in      <= 1'b0;
                    end else begin
                        r_bit_idx <= r_bit_idx + c_bit_w'(1);
                        det_in    <= r_burst[0];
                        r_burst   <= r_burst >> 1;
                    end
                end
                DRAIN: begin
                    r_hit_cnt <= w_hit_next;
                    if (r_drain_cnt == c_lat_w'(DET_LAT - 1)) begin
                        r_state    <= REPORT;
                        done_valid <= 1'b1;
                        done_id    <= r_gnt_idx;
                        done_hits  <= w_hit_next;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_lat_w'(1);
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_arbiter
// Purpose  : Directed, table-driven checks of seq_det_arbiter with a "1011"
//            detector model; second instance exercises hit-count saturation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_det_arbiter;

    localparam int N  = 4;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*BW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            det_rstn, det_in, det_out;
    logic            done_valid, busy;
    logic [1:0]      done_id;
    logic [3:0]      done_hits;

    logic [N-1:0]    s_valid = '0;
    logic [N*BW-1:0] s_data = '0;
    logic [N-1:0]    s_ready;
    logic            s_det_rstn, s_det_in, s_done_valid, s_busy;
    logic [1:0]      s_done_id;
    logic [1:0]      s_done_hits;

    always #5 clk = ~clk;

    seq_det_arbiter #(.N_REQ(N), .BURST_W(BW), .CNT_W(4), .DET_LAT(1)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .det_rstn(det_rstn), .det_in(det_in),
        .det_out(det_out), .done_valid(done_valid), .done_id(done_id),
        .done_hits(done_hits), .busy(busy)
    );

    seq_det_arbiter #(.N_REQ(N), .BURST_W(BW), .CNT_W(2), .DET_LAT(2)) u_sat (
        .clk(clk), .rstn(rstn), .req_valid(s_valid), .req_data(s_data),
        .req_ready(s_ready), .det_rstn(s_det_rstn), .det_in(s_det_in),
        .det_out(1'b1), .done_valid(s_done_valid), .done_id(s_done_id),
        .done_hits(s_done_hits), .busy(s_busy)
    );

    // "1011" detector (oldest bit first), one-cycle registered match.
    logic [2:0] hist;
    always @(posedge clk or negedge det_rstn) begin
        if (!det_rstn) begin
            hist    <= '0;
            det_out <= 1'b0;
        end else begin
            hist    <= {hist[1:0], det_in};
            det_out <= ({hist, det_in} == 4'b1011);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         g_cyc[$];
    logic [N-1:0] g_vec[$];
    logic       g_dr[$];
    int         d_cyc[$];
    int         d_id[$];
    int         d_hits[$];

    always @(negedge clk) begin
        if (req_ready != '0) begin
            g_cyc.push_back(cyc);
            g_vec.push_back(req_ready);
            g_dr.push_back(det_rstn);
        end
        if (done_valid) begin
            d_cyc.push_back(cyc);
            d_id.push_back(int'(done_id));
            d_hits.push_back(int'(done_hits));
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ids[4];
    int exp_hits[4];

    typedef struct {
        int         id;
        logic [7:0] data;
        int         hits;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        if (!$onehot(v)) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        g_cyc.delete(); g_vec.delete(); g_dr.delete();
        d_cyc.delete(); d_id.delete(); d_hits.delete();
    endtask

    task automatic run_until(input int n_done, input logic [N-1:0] hold);
        int t = 0;
        while (d_id.size() < n_done && t < 300) begin
            @(negedge clk); #1;
            t++;
            req_valid = req_valid & ~(req_ready & ~hold);
        end
        chk("done_count", d_id.size(), n_done);
    endtask

    task automatic settle();
        int t = 0;
        req_valid = '0;
        while (busy && t < 40) begin
            @(negedge clk); t++;
        end
        chk("settle_idle", int'(busy), 0);
        repeat (2) @(negedge clk);
        clear_logs();
    endtask

    task automatic check_seq(input string name, input int n, input int lat, input int spacing);
        for (int k = 0; k < n; k++) begin
            chk({name, "_grant"}, (k < g_vec.size()) ? idx_of(g_vec[k]) : -1, exp_ids[k]);
            chk({name, "_id"},    (k < d_id.size())  ? d_id[k] : -1, exp_ids[k]);
            chk({name, "_hits"},  (k < d_hits.size()) ? d_hits[k] : -1, exp_hits[k]);
            chk({name, "_lat"},   (k < d_cyc.size() && k < g_cyc.size()) ? d_cyc[k] - g_cyc[k] : -1, lat);
            if (k > 0 && spacing > 0)
                chk({name, "_space"}, (k < g_cyc.size()) ? g_cyc[k] - g_cyc[k-1] : -1, spacing);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{id: 0, data: 8'h0D, hits: 1};
        vecs[1] = '{id: 2, data: 8'hDD, hits: 2};
        vecs[2] = '{id: 1, data: 8'h6D, hits: 2};
        vecs[3] = '{id: 1, data: 8'hB0, hits: 0};
        vecs[4] = '{id: 3, data: 8'hFF, hits: 0};

        repeat (3) @(negedge clk);
        chk("rst_ready",    int'(req_ready), 0);
        chk("rst_det_rstn", int'(det_rstn), 0);
        chk("rst_det_in",   int'(det_in), 0);
        chk("rst_done_v",   int'(done_valid), 0);
        chk("rst_done_id",  int'(done_id), 0);
        chk("rst_hits",     int'(done_hits), 0);
        chk("rst_busy",     int'(busy), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_det_rstn", int'(det_rstn), 1);
        clear_logs();

        // Round-robin from pointer 0 with everyone requesting.
        for (int i = 0; i < N; i++) req_data[i*BW +: BW] = 8'h0D;
        req_valid = 4'b1111;
        run_until(4, '0);
        exp_ids  = '{0, 1, 2, 3};
        exp_hits = '{1, 1, 1, 1};
        check_seq("rr", 4, 10, 12);
        settle();

        for (int v = 0; v < 5; v++) begin
            req_data[vecs[v].id*BW +: BW] = vecs[v].data;
            req_valid[vecs[v].id] = 1'b1;
            run_until(1, '0);
            exp_ids[0]  = vecs[v].id;
            exp_hits[0] = vecs[v].hits;
            check_seq("vec", 1, 10, 0);
            settle();
        end

        // Tail 1,0,1 of one burst must not combine with the next burst's leading 1.
        req_data[0*BW +: BW] = 8'hA0;
        req_data[1*BW +: BW] = 8'h01;
        req_valid = 4'b0011;
        run_until(2, '0);
        exp_ids  = '{0, 1, 0, 0};
        exp_hits = '{0, 0, 0, 0};
        check_seq("xburst", 2, 10, 12);
        chk("xburst_clr0", (g_dr.size() > 0) ? int'(g_dr[0]) : -1, 0);
        chk("xburst_clr1", (g_dr.size() > 1) ? int'(g_dr[1]) : -1, 0);
        settle();

        // Requester 2 keeps requesting; pointer is 2 here.
        req_data[0*BW +: BW] = 8'h0D;
        req_data[2*BW +: BW] = 8'hDD;
        req_valid = 4'b0101;
        run_until(3, 4'b0100);
`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
        exp_ids  = '{0, 2, 2, 0};
        exp_hits = '{1, 2, 2, 0};
`else
        exp_ids  = '{2, 0, 2, 0};
        exp_hits = '{2, 1, 2, 0};
`endif
        check_seq("rearb", 3, 10, 12);
        settle();

        // Reset while shifting bit 4 of requester 1's burst.
        req_data[1*BW +: BW] = 8'h0D;
        req_valid = 4'b0010;
        for (int t = 0; t < 20 && g_vec.size() == 0; t++) begin
            @(negedge clk); #1;
        end
        chk("mid_grant", (g_vec.size() > 0) ? idx_of(g_vec[0]) : -1, 1);
        req_valid = '0;
        repeat (5) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_outs", int'({req_ready, det_rstn, det_in, done_valid, busy}), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_no_done", d_id.size(), 0);
        clear_logs();
        req_data[0*BW +: BW] = 8'h0D;
        req_data[3*BW +: BW] = 8'hDD;
        req_valid = 4'b1001;
        run_until(2, '0);
        exp_ids  = '{0, 3, 0, 0};
        exp_hits = '{1, 2, 0, 0};
        check_seq("post_rst", 2, 10, 12);
        settle();

        // Saturation: CNT_W=2, DET_LAT=2, det_out stuck high.
        begin
            int rc;
            int t;
            rc = -1;
            s_valid = 4'b0100;
            t = 0;
            while (s_ready == '0 && t < 20) begin
                @(negedge clk); #1; t++;
            end
            chk("sat_grant", idx_of(s_ready), 2);
            chk("sat_clr", int'(s_det_rstn), 0);
            rc = cyc;
            s_valid = '0;
            t = 0;
            while (!s_done_valid && t < 40) begin
                @(negedge clk); #1; t++;
            end
            chk("sat_id",   int'(s_done_id), 2);
            chk("sat_hits", int'(s_done_hits), 3);
            chk("sat_lat",  cyc - rc, 11);
            repeat (2) @(negedge clk);
            chk("sat_idle", int'({s_busy, s_det_in}), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
